// File: rtl/alu_accum_p_reg_27bits_18bits.sv
// Accumulator / P-register stage behind the 45-bit SIMD ALU: counts valid beats, feeds W back, emits P.
// Optional pattern detect on the P load is enabled by defining ALU_ACCUM_PATTERN_DETECT_EN.
module alu_accum_p_reg_27bits_18bits #(
    parameter int unsigned WIDTH = 45,
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       USE_SIMD_in,
    input  logic [LEN_W-1:0] acc_len,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] S,
    input  logic [7:0]       result_SIMD_carry_out,
`ifdef ALU_ACCUM_PATTERN_DETECT_EN
    input  logic [WIDTH-1:0] PATTERN,
    input  logic [WIDTH-1:0] MASK,
    output logic             PATTERNDETECT,
`endif
    output logic [1:0]       USE_SIMD,
    output logic [WIDTH-1:0] W,
    output logic [WIDTH-1:0] P,
    output logic             P_valid,
    output logic [7:0]       CARRY_P,
    output logic             busy
);

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    state_t           state_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] count_q;
    logic [WIDTH-1:0] acc_q;
    logic [1:0]       use_simd_q;
    logic [WIDTH-1:0] p_q;
    logic [7:0]       carry_p_q;
    logic             p_valid_q;

    logic [LEN_W-1:0] len_eff;
    logic [LEN_W-1:0] count_inc;
    logic             last_beat;
    logic             load_p;

    always_comb begin
        len_eff = acc_len;
        if (acc_len == '0) begin
            len_eff = LEN_W'(1);
        end
    end

    assign count_inc = count_q + LEN_W'(1);
    assign last_beat = (count_inc == len_q);

    // P loads either on a single-beat run straight out of IDLE or on the final beat in ACC.
    always_comb begin
        load_p = 1'b0;
        if (in_valid) begin
            if (state_q == IDLE) begin
                load_p = (len_eff == LEN_W'(1));
            end else begin
                load_p = last_beat;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            len_q      <= LEN_W'(1);
            count_q    <= '0;
            acc_q      <= '0;
            use_simd_q <= 2'b00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        use_simd_q <= USE_SIMD_in;
                        len_q      <= len_eff;
                        count_q    <= LEN_W'(1);
                        if (len_eff != LEN_W'(1)) begin
                            acc_q   <= S;
                            state_q <= ACC;
                        end
                    end
                end
                ACC: begin
                    if (in_valid) begin
                        if (last_beat) begin
                            acc_q   <= '0;
                            count_q <= '0;
                            state_q <= IDLE;
                        end else begin
                            acc_q   <= S;
                            count_q <= count_inc;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_q       <= '0;
            carry_p_q <= '0;
            p_valid_q <= 1'b0;
        end else begin
            p_valid_q <= load_p;
            if (load_p) begin
                p_q       <= S;
                carry_p_q <= result_SIMD_carry_out;
            end
        end
    end

`ifdef ALU_ACCUM_PATTERN_DETECT_EN
    logic pd_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pd_q <= 1'b0;
        end else if (load_p) begin
            pd_q <= (((S ^ PATTERN) & ~MASK) == '0);
        end
    end

    assign PATTERNDETECT = pd_q;
`endif

    assign W        = (state_q == ACC) ? acc_q : '0;
    assign busy     = (state_q == ACC);
    assign USE_SIMD = use_simd_q;
    assign P        = p_q;
    assign P_valid  = p_valid_q;
    assign CARRY_P  = carry_p_q;

endmodule

// File: doc/alu_accum_p_reg_27bits_18bits.md
Name: alu_accum_p_reg_27bits_18bits

Overview:
- Output/accumulator stage directly downstream of the 45-bit SIMD ALU (lanes 17/10/8/10 bits, modes 27x18, sum-9x9, sum-4x4).
- Registers the ALU sum S and the lane carries, and feeds the running accumulator back as the ALU W operand.
- Counts a programmable number of valid beats, then emits the final accumulated P with a one-cycle valid pulse.
- Also owns the registered USE_SIMD that drives the ALU, so the mode cannot change mid-accumulation.

Parameters:
- WIDTH, 45, datapath width; must equal the ALU width.
- LEN_W, 8, width of the accumulation-length field.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- USE_SIMD_in  input  2  requested mode; sampled only at the first beat of a run.
- acc_len  input  LEN_W  beats per run; sampled at the first beat; 0 is treated as 1.
- in_valid  input  1  current S and carries are a valid beat.
- S  input  WIDTH  ALU sum.
- result_SIMD_carry_out  input  8  ALU lane carries, 2 per lane.
- USE_SIMD  output  2  registered mode to the ALU.
- W  output  WIDTH  accumulator feedback to the ALU W operand.
- P  output  WIDTH  final result of a run.
- P_valid  output  1  one-cycle pulse when P updates.
- CARRY_P  output  8  lane carries registered with P.
- busy  output  1  high in ACC state.

Behaviour:
- Reset values (async): USE_SIMD=2'b00, W=0, P=0, P_valid=0, CARRY_P=0, busy=0, state=IDLE, count=0, len_q=1.
- W is combinational from state: W = acc_q in ACC, else 0. The first beat of a run therefore computes S = X+Y+0.
- IDLE, in_valid=1:
  - USE_SIMD<=USE_SIMD_in; len_q<=max(acc_len,1); count<=1.
  - If len_q would be 1: P<=S, CARRY_P<=carries, P_valid<=1 next cycle, stay IDLE.
  - Else: acc_q<=S, go to ACC.
- IDLE, in_valid=0: hold; P_valid<=0.
- ACC, in_valid=1, count+1<len_q: acc_q<=S; count<=count+1.
- ACC, in_valid=1, count+1==len_q:
  - P<=S; CARRY_P<=carries; P_valid<=1.
  - acc_q<=0; count<=0; go to IDLE.
  - A new run may start on the very next cycle; back-to-back runs have no bubble.
- ACC, in_valid=0: all state held (stall); W keeps driving acc_q.
- P_valid is high for exactly one cycle per completed run. P and CARRY_P hold their values until the next completion.
- Arithmetic: no width growth, no saturation. acc_q is WIDTH bits, and lane wrap-around follows ALU carry gating. CARRY_P is captured raw; the bench decodes it per mode.
- USE_SIMD_in changes during ACC are ignored until the next run's first beat.
- Reset asserted mid-run:
  - Immediately clears to reset values; W drops to 0 combinationally.
  - The partial accumulation is lost; no P_valid is generated.
- Latency: P_valid asserts 1 cycle after the last valid beat.

Optional Feature:
- Macro: ALU_ACCUM_PATTERN_DETECT_EN.
- Defined:
  - Adds inputs PATTERN[WIDTH-1:0] and MASK[WIDTH-1:0], and output PATTERNDETECT (reset 0).
  - PATTERNDETECT registers ((S ^ PATTERN) & ~MASK)==0 on the same edge that loads P, and holds until the next completion.
- Undefined: none of these ports or logic exist.

Test Plan:
- Reset, then acc_len=1, in_valid one cycle, S=45'h1234 -> next cycle P=45'h1234, P_valid=1 for 1 cycle, W=0 throughout.
- acc_len=4, USE_SIMD_in=00, bench ALU adds X=5 each beat -> W sequence 0,5,10,15; P=20 with one P_valid.
- acc_len=3, in_valid pattern 1,0,0,1,1 -> W holds during the gaps; P_valid exactly one cycle after the 5th cycle; busy high from cycle 2 to completion.
- USE_SIMD_in=10 at the first beat, switched to 00 mid-run -> USE_SIMD stays 10 until the run completes, then takes the new value at the next first beat.
- Reset pulsed at beat 2 of acc_len=4 -> W=0 and busy=0 immediately, no P_valid; a subsequent run with acc_len=2, S=7 then 9 -> P=9.
- With ALU_ACCUM_PATTERN_DETECT_EN: PATTERN=45'h0, MASK=0, final S=0 -> PATTERNDETECT=1; final S=1 -> PATTERNDETECT=0.
